// File: rtl/multi_sync.sv
// multi_sync: bank of independent multi-flop synchronisers for Gray-coded
// buses crossing into the i_clk domain, with Gray-to-binary conversion,
// per-channel change pulses and optional Gray-violation monitoring.
//
// Parameters:
//   CH      number of independent channels
//   WIDTH   bits per channel (Gray-coded pointer width)
//   STAGES  flops per synchroniser chain, legal range 2..4
//   ERR_W   width of the saturating error-cycle counter
//
// Ports:
//   i_clk       destination-domain clock, all state on posedge
//   i_rst_n     asynchronous active-low reset (deassertion must already be
//               synchronised to i_clk by the reset generator)
//   i_data      asynchronous Gray values, channel c at [c*WIDTH +: WIDTH]
//   i_err_clr   synchronous clear of error flags and counter
//   o_sync      synchronised Gray values, same packing as i_data
//   o_bin       combinational binary decode of o_sync, per channel
//   o_chg       per-channel pulse while o_sync differs from last cycle
//   o_gray_err  per-channel sticky flag: more than one bit changed at once
//   o_err_cnt   saturating count of cycles with at least one violation
//
// Build option:
//   MULTI_SYNC_GRAY_CHECK_EN  when defined, the violation detector, sticky
//   flags and counter are built; otherwise o_gray_err and o_err_cnt are tied
//   to zero and i_err_clr is ignored.

module multi_sync #(
  parameter int CH     = 2,
  parameter int WIDTH  = 5,
  parameter int STAGES = 2,
  parameter int ERR_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CH*WIDTH-1:0] i_data,
  input  logic                i_err_clr,
  output logic [CH*WIDTH-1:0] o_sync,
  output logic [CH*WIDTH-1:0] o_bin,
  output logic [CH-1:0]       o_chg,
  output logic [CH-1:0]       o_gray_err,
  output logic [ERR_W-1:0]    o_err_cnt
);

  localparam int N = CH * WIDTH;

  logic [N-1:0] sync_d [STAGES];
  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] prev_d;
  logic [N-1:0] prev_q;

  // Pure wiring between chain stages: each bit gets its own flop chain with
  // nothing in between, so metastability has a full cycle to resolve.
  always_comb begin
    sync_d[0] = i_data;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign prev_d = o_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];

  // Gray to binary: running XOR from the MSB downwards within each channel.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    o_bin = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 1'b0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
        acc = acc ^ o_sync[c*WIDTH + k];
        o_bin[c*WIDTH + k] = acc;
      end
    end
  end

  always_comb begin
    o_chg = '0;
    for (int c = 0; c < CH; c++) begin
      o_chg[c] = (o_sync[c*WIDTH +: WIDTH] != prev_q[c*WIDTH +: WIDTH]);
    end
  end

`ifdef MULTI_SYNC_GRAY_CHECK_EN
  logic [CH-1:0]    viol;
  logic [CH-1:0]    gray_err_d;
  logic [CH-1:0]    gray_err_q;
  logic [ERR_W-1:0] err_cnt_d;
  logic [ERR_W-1:0] err_cnt_q;

  // diff & (diff - 1) is non-zero exactly when more than one bit is set,
  // i.e. the synchronised value moved by more than one Gray step. For
  // WIDTH=1 it can never fire.
  always_comb begin
    logic [WIDTH-1:0] diff;
    diff = '0;
    viol = '0;
    for (int c = 0; c < CH; c++) begin
      diff    = o_sync[c*WIDTH +: WIDTH] ^ prev_q[c*WIDTH +: WIDTH];
      viol[c] = |(diff & (diff - WIDTH'(1)));
    end
  end

  // A clear coinciding with a violation still records that violation: the
  // flags of violating channels stay set and the counter restarts at 1.
  always_comb begin
    gray_err_d = (i_err_clr ? '0 : gray_err_q) | viol;
    if (|viol) begin
      if (i_err_clr) begin
        err_cnt_d = ERR_W'(1);
      end else if (&err_cnt_q) begin
        err_cnt_d = err_cnt_q;
      end else begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (i_err_clr) begin
      err_cnt_d = '0;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gray_err_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      gray_err_q <= gray_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_gray_err = gray_err_q;
  assign o_err_cnt  = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = i_err_clr;
  assign o_gray_err     = '0;
  assign o_err_cnt      = '0;
`endif

endmodule

// File: doc/multi_sync.md
MULTI_SYNC -- requirements
Module: multi_sync

Interface
REQ-001 Parameter CH, default 2: number of independent channels.
REQ-002 Parameter WIDTH, default 5: bits per channel (pointer width ADDR+1).
REQ-003 Parameter STAGES, default 2: flops per synchroniser chain; legal range 2..4.
REQ-004 Parameter ERR_W, default 8: width of the error counter.
REQ-005 i_clk  input  1  destination-domain clock; all state on posedge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_data  input  CH*WIDTH  asynchronous Gray-coded values; channel c at bits [c*WIDTH +: WIDTH].
REQ-008 i_err_clr  input  1  synchronous clear of error flags and counter.
REQ-009 o_sync  output  CH*WIDTH  synchronised Gray values, same packing as i_data.
REQ-010 o_bin  output  CH*WIDTH  Gray-to-binary conversion of o_sync, per channel.
REQ-011 o_chg  output  CH  per-channel one-cycle change pulse.
REQ-012 o_gray_err  output  CH  per-channel sticky Gray-violation flag.
REQ-013 o_err_cnt  output  ERR_W  saturating count of error cycles.

Function
REQ-014 Each of the CH*WIDTH bits SHALL pass through its own STAGES-deep flop chain; o_sync bit = last flop, no logic between flops.
REQ-015 A value held stable on i_data across STAGES rising edges SHALL appear on o_sync after exactly STAGES edges.
REQ-016 o_bin SHALL be combinational from o_sync: bin[MSB]=g[MSB], bin[k]=bin[k+1] XOR g[k]; zero added latency.
REQ-017 A per-channel register prev SHALL capture o_sync every cycle.
REQ-018 o_chg[c] SHALL be 1 exactly in cycles where channel c of o_sync differs from prev[c]; a single input change yields one 1-cycle pulse.
REQ-019 Gray violation for channel c: popcount(o_sync[c] XOR prev[c]) > 1.
REQ-020 On a violation, o_gray_err[c] SHALL be set on the next edge and held until cleared.
REQ-021 o_err_cnt SHALL increment by 1 per cycle in which at least one channel violates (not per channel), saturating at 2^ERR_W-1.
REQ-022 i_err_clr=1 SHALL clear all o_gray_err bits and o_err_cnt on the next edge.
REQ-023 Simultaneous i_err_clr and violation: set wins; flags of violating channels = 1; o_err_cnt loads 1.
REQ-024 WIDTH=1: violation impossible; o_gray_err and o_err_cnt stay 0.
REQ-025 Channels SHALL be fully independent; no cross-channel ordering guaranteed.

Reset
REQ-026 Assertion of i_rst_n=0 SHALL immediately zero all sync flops, prev, o_gray_err, o_err_cnt, independent of i_clk.
REQ-027 During and after reset, o_sync=0, o_bin=0, o_chg=0 until input propagates.
REQ-028 Reset mid-operation SHALL discard in-flight values; first post-reset change SHALL produce no spurious violation from pre-reset state.
REQ-029 Deassertion SHALL be synchronised to i_clk externally.

Configuration
REQ-030 Macro MULTI_SYNC_GRAY_CHECK_EN: defined -> REQ-019..REQ-024 logic present.
REQ-031 Not defined -> no violation logic or counter; o_gray_err and o_err_cnt tied to 0; i_err_clr ignored; REQ-014..REQ-018 unchanged.

Verification
REQ-032 Reset, CH=2, WIDTH=5, STAGES=2; ch0 i_data 00000->00001 -> o_sync ch0=00001 after 2 edges, o_chg[0] 1 for one cycle, o_bin ch0=00001, no error.
REQ-033 Ch1 Gray 00001->00011 (bin 1->2) with STAGES=3 -> o_sync after 3 edges, o_bin ch1=00010, o_chg[1] single pulse.
REQ-034 Ch0 jumps 00000->00111 (3 bits) -> o_gray_err[0]=1 next edge, o_err_cnt=1; ch1 flag stays 0.
REQ-035 Violations on both channels same cycle -> o_err_cnt +1 only; repeat 300 violation cycles with ERR_W=8 -> o_err_cnt holds 255.
REQ-036 i_err_clr in same cycle as new violation on ch1 -> o_gray_err=2'b10, o_err_cnt=1.
REQ-037 i_rst_n pulsed low mid-propagation with ch0=11111 in chain -> outputs 0 immediately, no o_chg/o_gray_err after release until i_data changes; rerun with macro undefined -> o_gray_err, o_err_cnt always 0.
